// File: rtl/sgb_rom_arb_pkg.sv
// Shared types and constants for the SGB ROM port arbiter.
package sgb_rom_arb_pkg;

  localparam int ADDR_W = 25;

  localparam logic [1:0] PORT_DL   = 2'd0;
  localparam logic [1:0] PORT_SNES = 2'd1;
  localparam logic [1:0] PORT_GB   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_DL   = 2'd1,
    ST_GRANT_SNES = 2'd2,
    ST_GRANT_GB   = 2'd3
  } arb_state_e;

  // GB reads one byte of the 16-bit word, chosen by byte address bit 0
  function automatic logic [7:0] gb_byte_sel(input logic [15:0] q, input logic hi);
    return hi ? q[15:8] : q[7:0];
  endfunction

endpackage

// File: rtl/sgb_req_latch.sv
// One-deep pending request latch. A strobe on the grant edge queues behind the
// granted contents; a strobe onto an ungranted pending request sets overrun.
module sgb_req_latch #(
  parameter int AW = 25,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_strobe,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_grant,
  output logic          o_pend,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_overrun
);

  logic          r_pend;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend    <= 1'b0;
      r_addr    <= {AW{1'b0}};
      r_data    <= {DW{1'b0}};
      r_overrun <= 1'b0;
    end else if (i_strobe) begin
      r_pend <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
      if (r_pend && !i_grant) begin
        r_overrun <= 1'b1;
      end
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend    = r_pend;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sgb_rom_arbiter.sv
// Arbitrates the shared 16-bit ROM port between download writes, GB reads and
// SNES fetches: DL first, then a starved GB, then SNES, then GB.
module sgb_rom_arbiter import sgb_rom_arb_pkg::*; #(
  parameter logic [ADDR_W-1:0] SNES_BASE   = 25'h0000000,
  parameter logic [ADDR_W-1:0] GB_BASE     = 25'h0800000,
  parameter int                GB_MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_snes_rd,
  input  logic [23:0]       i_snes_addr,
  output logic [15:0]       o_snes_q,
  output logic              o_snes_valid,
  input  logic              i_gb_rd,
  input  logic [22:0]       i_gb_addr,
  output logic [7:0]        o_gb_q,
  output logic              o_gb_valid,
  input  logic              i_dl_wr,
  input  logic [24:0]       i_dl_addr,
  input  logic [15:0]       i_dl_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_din,
  input  logic              i_mem_ack,
  input  logic [15:0]       i_mem_q,
  output logic              o_overrun
);

  localparam logic [7:0] LP_GB_MAX = 8'(GB_MAX_WAIT);

  logic              w_dl_pend, w_snes_pend, w_gb_pend;
  logic [24:0]       w_dl_addr;
  logic [23:0]       w_snes_addr;
  logic [22:0]       w_gb_addr;
  logic [15:0]       w_dl_data, w_snes_data, w_gb_data;
  logic              w_dl_ovr, w_snes_ovr, w_gb_ovr;
  logic              w_grant_dl, w_grant_snes, w_grant_gb, w_grant_any, w_done, w_gb_starved;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_win_we;
  logic [15:0]       w_win_din;
  logic [1:0]        w_win_port;
  arb_state_e        r_state, w_state_nxt;

  logic              r_mem_req, r_mem_we, r_snes_valid, r_gb_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_din, r_snes_q;
  logic [7:0]        r_gb_q, r_gb_wait;
  logic [1:0]        r_port;

  sgb_req_latch #(.AW(25), .DW(16)) u_dl_latch (
    .i_clk(i_clk), .i_reset(i_reset), .i_strobe(i_dl_wr), .i_addr(i_dl_addr), .i_data(i_dl_data),
    .i_grant(w_grant_dl), .o_pend(w_dl_pend), .o_addr(w_dl_addr), .o_data(w_dl_data), .o_overrun(w_dl_ovr)
  );

  sgb_req_latch #(.AW(24), .DW(16)) u_snes_latch (
    .i_clk(i_clk), .i_reset(i_reset), .i_strobe(i_snes_rd), .i_addr(i_snes_addr), .i_data(16'h0000),
    .i_grant(w_grant_snes), .o_pend(w_snes_pend), .o_addr(w_snes_addr), .o_data(w_snes_data), .o_overrun(w_snes_ovr)
  );

  sgb_req_latch #(.AW(23), .DW(16)) u_gb_latch (
    .i_clk(i_clk), .i_reset(i_reset), .i_strobe(i_gb_rd), .i_addr(i_gb_addr), .i_data(16'h0000),
    .i_grant(w_grant_gb), .o_pend(w_gb_pend), .o_addr(w_gb_addr), .o_data(w_gb_data), .o_overrun(w_gb_ovr)
  );

  assign w_gb_starved = w_gb_pend && (r_gb_wait >= LP_GB_MAX);
  assign w_grant_any  = w_grant_dl | w_grant_snes | w_grant_gb;
  assign w_done       = (r_state != ST_IDLE) && i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dl_pend)          w_state_nxt = ST_GRANT_DL;
        else if (w_gb_starved)  w_state_nxt = ST_GRANT_GB;
        else if (w_snes_pend)   w_state_nxt = ST_GRANT_SNES;
        else if (w_gb_pend)     w_state_nxt = ST_GRANT_GB;
        else                    w_state_nxt = ST_IDLE;
      end
      ST_GRANT_DL, ST_GRANT_SNES, ST_GRANT_GB: begin
        if (i_mem_ack) w_state_nxt = ST_IDLE;
        else           w_state_nxt = r_state;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant_dl   = 1'b0;
    w_grant_snes = 1'b0;
    w_grant_gb   = 1'b0;
    w_win_addr   = {ADDR_W{1'b0}};
    w_win_we     = 1'b0;
    w_win_din    = 16'h0000;
    w_win_port   = PORT_DL;
    if (r_state == ST_IDLE) begin
      case (w_state_nxt)
        ST_GRANT_DL: begin
          w_grant_dl = 1'b1;
          w_win_addr = w_dl_addr;
          w_win_we   = 1'b1;
          w_win_din  = w_dl_data;
          w_win_port = PORT_DL;
        end
        ST_GRANT_SNES: begin
          w_grant_snes = 1'b1;
          w_win_addr   = SNES_BASE | {1'b0, w_snes_addr};
          w_win_din    = w_snes_data;
          w_win_port   = PORT_SNES;
        end
        ST_GRANT_GB: begin
          w_grant_gb = 1'b1;
          w_win_addr = GB_BASE | {2'b00, w_gb_addr};
          w_win_din  = w_gb_data;
          w_win_port = PORT_GB;
        end
        default: w_win_we = 1'b0;
      endcase
    end else begin
      w_win_we = 1'b0;
    end
  end

  // Bus is loaded on grant and frozen until ack; read data lands one cycle after ack
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_din    <= 16'h0000;
      r_port       <= PORT_DL;
      r_snes_q     <= 16'h0000;
      r_snes_valid <= 1'b0;
      r_gb_q       <= 8'h00;
      r_gb_valid   <= 1'b0;
    end else begin
      r_snes_valid <= 1'b0;
      r_gb_valid   <= 1'b0;
      if (w_grant_any) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= w_win_we;
        r_mem_addr <= w_win_addr;
        r_mem_din  <= w_win_din;
        r_port     <= w_win_port;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_port == PORT_SNES) begin
          r_snes_q     <= i_mem_q;
          r_snes_valid <= 1'b1;
        end
        if (r_port == PORT_GB) begin
          r_gb_q     <= gb_byte_sel(i_mem_q, r_mem_addr[0]);
          r_gb_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_gb_pend || w_grant_gb) begin
      r_gb_wait <= 8'h00;
    end else if (r_gb_wait != 8'hFF) begin
      r_gb_wait <= r_gb_wait + 8'h01;
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;
  assign o_snes_q     = r_snes_q;
  assign o_snes_valid = r_snes_valid;
  assign o_gb_q       = r_gb_q;
  assign o_gb_valid   = r_gb_valid;
  assign o_overrun    = w_dl_ovr | w_snes_ovr | w_gb_ovr;

endmodule

// File: tb/tb_sgb_rom_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// transaction-level model of pending requests, priority and memory timing.
module tb_sgb_rom_arbiter;

  localparam int P_DL = 0, P_SNES = 1, P_GB = 2;
  localparam int GB_MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        i_reset, i_snes_rd, i_gb_rd, i_dl_wr, i_mem_ack;
  logic [23:0] i_snes_addr;
  logic [22:0] i_gb_addr;
  logic [24:0] i_dl_addr;
  logic [15:0] i_dl_data, i_mem_q;
  logic [15:0] o_snes_q, o_mem_din;
  logic [7:0]  o_gb_q;
  logic [24:0] o_mem_addr;
  logic        o_snes_valid, o_gb_valid, o_mem_req, o_mem_we, o_overrun;

  always #5 clk = ~clk;

  sgb_rom_arbiter dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_snes_rd(i_snes_rd), .i_snes_addr(i_snes_addr), .o_snes_q(o_snes_q), .o_snes_valid(o_snes_valid),
    .i_gb_rd(i_gb_rd), .i_gb_addr(i_gb_addr), .o_gb_q(o_gb_q), .o_gb_valid(o_gb_valid),
    .i_dl_wr(i_dl_wr), .i_dl_addr(i_dl_addr), .i_dl_data(i_dl_data),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
    .i_mem_ack(i_mem_ack), .i_mem_q(i_mem_q), .o_overrun(o_overrun)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic        m_pend [3];
  logic [24:0] m_addr [3];
  logic [15:0] m_din  [3];
  int          m_gb_since;
  logic        m_ovr;
  logic        prev_req, ack_next, cfg_qfix, force_ack;
  int          req_cnt, ack_k, cfg_k, cur_port, granted_now;
  logic [15:0] cfg_q, ack_q;
  logic [24:0] cur_addr;
  int          grant_log[$];
  logic [24:0] grant_addr_log[$];
  int          n_gb_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Priority rule; a GB request waiting since edge S has been counted E-S-1 cycles at edge E
  function automatic int pick_winner();
    if (m_pend[P_DL]) return P_DL;
    if (m_pend[P_GB] && (cyc - m_gb_since - 1) >= GB_MAX_WAIT) return P_GB;
    if (m_pend[P_SNES]) return P_SNES;
    return P_GB;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    m_ovr = 1'b0; prev_req = 1'b0; ack_next = 1'b0; req_cnt = 0;
  endtask

  task automatic capture(input int p, input logic [24:0] a, input logic [15:0] d);
    if (m_pend[p]) m_ovr = 1'b1;
    else if (p == P_GB) m_gb_since = cyc;
    m_pend[p] = 1'b1; m_addr[p] = a; m_din[p] = d;
  endtask

  task automatic step();
    logic exp_req, exp_sv, exp_gv;
    @(posedge clk); cyc++; #1;
    granted_now = -1;
    if (i_reset) begin
      model_reset();
      chk("rst_req", o_mem_req, 1'b0);
      chk("rst_valid", {o_snes_valid, o_gb_valid}, 2'b00);
      chk("rst_overrun", o_overrun, 1'b0);
      chk("rst_q", {o_snes_q, o_gb_q}, 24'h0);
      chk("rst_addr", o_mem_addr, 25'h0);
    end else begin
      exp_req = prev_req ? !ack_next : (m_pend[0] | m_pend[1] | m_pend[2]);
      chk("mem_req", o_mem_req, exp_req);
      exp_sv = prev_req && ack_next && (cur_port == P_SNES);
      exp_gv = prev_req && ack_next && (cur_port == P_GB);
      chk("snes_valid", o_snes_valid, exp_sv);
      chk("gb_valid", o_gb_valid, exp_gv);
      if (exp_sv) chk("snes_q", o_snes_q, ack_q);
      if (exp_gv) chk("gb_q", o_gb_q, cur_addr[0] ? ack_q[15:8] : ack_q[7:0]);
      if (o_gb_valid) n_gb_valid++;
      if (!prev_req && o_mem_req) begin
        cur_port = pick_winner();
        cur_addr = m_addr[cur_port];
        chk("grant_addr", o_mem_addr, cur_addr);
        chk("grant_we", o_mem_we, cur_port == P_DL);
        if (cur_port == P_DL) chk("grant_din", o_mem_din, m_din[P_DL]);
        m_pend[cur_port] = 1'b0;
        granted_now = cur_port;
        grant_log.push_back(cur_port);
        grant_addr_log.push_back(cur_addr);
        req_cnt = 0;
        ack_k = (cfg_k > 0) ? cfg_k : int'($urandom_range(1, 4));
      end else if (prev_req && o_mem_req) begin
        chk("hold_addr", o_mem_addr, cur_addr);
      end
      if (i_dl_wr)   capture(P_DL, i_dl_addr, i_dl_data);
      if (i_snes_rd) capture(P_SNES, {1'b0, i_snes_addr}, 16'h0);
      if (i_gb_rd)   capture(P_GB, 25'h0800000 | {2'b00, i_gb_addr}, 16'h0);
      chk("overrun", o_overrun, m_ovr);
      prev_req = o_mem_req;
    end
    ack_next = 1'b0; i_mem_ack = 1'b0;
    i_mem_q = cfg_qfix ? cfg_q : 16'($urandom);
    if (o_mem_req && !i_reset) begin
      req_cnt++;
      if (req_cnt >= ack_k) begin ack_next = 1'b1; i_mem_ack = 1'b1; ack_q = i_mem_q; end
    end else if (force_ack) begin
      i_mem_ack = 1'b1;
    end
    i_snes_rd = 1'b0; i_gb_rd = 1'b0; i_dl_wr = 1'b0;
  endtask

  initial begin
    int first_gb, n_snes, t5_idx;
    logic gb_again;
    i_reset = 1'b1; i_snes_rd = 1'b0; i_gb_rd = 1'b0; i_dl_wr = 1'b0; i_mem_ack = 1'b0;
    i_snes_addr = 24'h0; i_gb_addr = 23'h0; i_dl_addr = 25'h0; i_dl_data = 16'h0; i_mem_q = 16'h0;
    cfg_k = 2; cfg_qfix = 1'b0; cfg_q = 16'h0; force_ack = 1'b0; m_gb_since = 0;
    cur_port = 0; cur_addr = 25'h0; ack_k = 1; ack_q = 16'h0; n_gb_valid = 0;
    model_reset();
    step(); step();
    i_reset = 1'b0;
    step();

    // T1: SNES fetch, ack on 2nd request cycle
    cfg_k = 2; cfg_qfix = 1'b1; cfg_q = 16'hA55A;
    i_snes_rd = 1'b1; i_snes_addr = 24'h008123;
    step();
    chk("t1_req_n", o_mem_req, 1'b0);
    step();
    chk("t1_req_n1", o_mem_req, 1'b1);
    chk("t1_addr", o_mem_addr, 25'h0008123);
    chk("t1_we", o_mem_we, 1'b0);
    step();
    chk("t1_req_n2", o_mem_req, 1'b1);
    step();
    chk("t1_valid", o_snes_valid, 1'b1);
    chk("t1_q", o_snes_q, 16'hA55A);
    chk("t1_req_low", o_mem_req, 1'b0);
    repeat (3) step();

    // T2: GB read of the odd byte
    cfg_k = 1; cfg_q = 16'h3C7E; n_gb_valid = 0; grant_addr_log.delete();
    i_gb_rd = 1'b1; i_gb_addr = 23'h000101;
    repeat (6) step();
    chk("t2_addr", grant_addr_log.size() == 1 ? grant_addr_log[0] : 25'h1FFFFFF, 25'h0800101);
    chk("t2_gb_q", o_gb_q, 8'h3C);
    chk("t2_pulses", n_gb_valid, 1);

    // T3: all three on one edge
    cfg_k = 2; cfg_qfix = 1'b0; grant_log.delete();
    i_dl_wr = 1'b1; i_dl_addr = 25'h1234567; i_dl_data = 16'hBEEF;
    i_snes_rd = 1'b1; i_snes_addr = 24'h00ABCD;
    i_gb_rd = 1'b1; i_gb_addr = 23'h000200;
    repeat (15) step();
    chk("t3_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t3_order", {grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0]},
          {2'(P_DL), 2'(P_SNES), 2'(P_GB)});
    end

    // T4: SNES kept pending on every idle cycle; GB must break through after GB_MAX_WAIT
    cfg_k = 1; grant_log.delete(); gb_again = 1'b0;
    i_snes_rd = 1'b1; i_snes_addr = 24'h000400;
    i_gb_rd = 1'b1; i_gb_addr = 23'h000300;
    for (int i = 0; i < 24; i++) begin
      step();
      if (granted_now == P_SNES) begin i_snes_rd = 1'b1; i_snes_addr = 24'($urandom); end
      if (granted_now == P_GB && !gb_again) begin
        gb_again = 1'b1; i_gb_rd = 1'b1; i_gb_addr = 23'($urandom);
      end
    end
    repeat (20) step();
    first_gb = -1;
    foreach (grant_log[i]) if (first_gb < 0 && grant_log[i] == P_GB) first_gb = i;
    chk("t4_first_gb", first_gb, 4);
    chk("t4_after_gb", (grant_log.size() > 5) ? grant_log[5] : -1, P_SNES);

    // T5: two SNES strobes while the port is busy with a download
    cfg_k = 3; grant_log.delete(); grant_addr_log.delete();
    i_dl_wr = 1'b1; i_dl_addr = 25'($urandom); i_dl_data = 16'($urandom);
    step();
    i_snes_rd = 1'b1; i_snes_addr = 24'h000010;
    step();
    i_snes_rd = 1'b1; i_snes_addr = 24'h000020;
    step();
    chk("t5_overrun_set", o_overrun, 1'b1);
    repeat (12) step();
    n_snes = 0; t5_idx = -1;
    foreach (grant_log[i]) if (grant_log[i] == P_SNES) begin n_snes++; t5_idx = i; end
    chk("t5_snes_grants", n_snes, 1);
    chk("t5_addr", (t5_idx >= 0) ? grant_addr_log[t5_idx] : 25'h1FFFFFF, 25'h0000020);
    chk("t5_overrun_sticky", o_overrun, 1'b1);
    i_reset = 1'b1; step(); i_reset = 1'b0;
    chk("t5_overrun_clr", o_overrun, 1'b0);

    // T6: reset during a GB access, then a stray ack
    cfg_k = 50; n_gb_valid = 0;
    i_gb_rd = 1'b1; i_gb_addr = 23'h000055;
    step(); step(); step();
    chk("t6_in_grant", o_mem_req, 1'b1);
    i_reset = 1'b1; step(); i_reset = 1'b0;
    chk("t6_req_drop", o_mem_req, 1'b0);
    force_ack = 1'b1; step(); force_ack = 1'b0;
    repeat (5) step();
    chk("t6_no_valid", n_gb_valid, 0);
    chk("t6_req_idle", o_mem_req, 1'b0);

    // Random traffic
    cfg_k = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_dl_wr = 1'b1; i_dl_addr = 25'($urandom); i_dl_data = 16'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin i_snes_rd = 1'b1; i_snes_addr = 24'($urandom); end
      if ($urandom_range(0, 3) == 0) begin i_gb_rd = 1'b1; i_gb_addr = 23'($urandom); end
      force_ack = ($urandom_range(0, 15) == 0);
      i_reset = ($urandom_range(0, 499) == 0);
      step();
    end
    i_reset = 1'b0; force_ack = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
